// File: rtl/sample_pos_accum_ram.sv
// Per-channel sample-position accumulator over a single-port-write/registered-read RAM.
// Two-stage read-modify-write pipeline with forwarding, plus a clear sweep FSM.
module sample_pos_accum_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_inc,
   input  logic                  req_sync,
   output logic                  rsp_valid,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [DATA_WIDTH-1:0] rsp_pos,
   output logic                  rsp_wrap
);
   typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic [1:0]            vld_pipe_q, vld_pipe_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
   logic [DATA_WIDTH-1:0] s1_inc_q, s1_inc_d, s2_inc_q, s2_inc_d;
   logic                  s1_sync_q, s1_sync_d, s2_sync_q, s2_sync_d;
   logic                  wb_vld_q, wb_vld_d;
   logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_WIDTH-1:0] rsp_pos_q, rsp_pos_d;
   logic                  rsp_wrap_q, rsp_wrap_d;
   logic                  busy_q, busy_d;

   logic                  accept;
   logic [DATA_WIDTH-1:0] old_pos, new_pos;
   logic [DATA_WIDTH:0]   sum;
   logic                  new_wrap;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_pos   = rsp_pos_q;
   assign rsp_wrap  = rsp_wrap_q;

   // The RAM read coincides with the previous request's writeback and returns
   // the pre-write word, so the last write is forwarded on an address match.
   always_comb begin
      req_ready = (state_q == RUN) && !clear_req;
      accept    = req_valid && req_ready;
      old_pos   = (wb_vld_q && (wb_addr_q == s2_addr_q)) ? wb_data_q : rd_q;
      sum       = {1'b0, old_pos} + {1'b0, s2_inc_q};
      new_pos   = s2_sync_q ? '0 : sum[DATA_WIDTH-1:0];
      new_wrap  = !s2_sync_q && sum[DATA_WIDTH];
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s2_addr_q;
      ram_wdata = new_pos;
      if (!reset) begin
         if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
         end else begin
            ram_we = vld_pipe_q[1];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == '1) state_d = RUN;
         end
         RUN:   if (clear_req) state_d = DRAIN;
         DRAIN: if (vld_pipe_q == '0) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
         end
         default: state_d = CLEAR;
      endcase

      vld_pipe_d = {vld_pipe_q[0], accept};
      s1_addr_d  = accept ? req_addr : s1_addr_q;
      s1_inc_d   = accept ? req_inc  : s1_inc_q;
      s1_sync_d  = accept ? req_sync : s1_sync_q;
      s2_addr_d  = vld_pipe_q[0] ? s1_addr_q : s2_addr_q;
      s2_inc_d   = vld_pipe_q[0] ? s1_inc_q  : s2_inc_q;
      s2_sync_d  = vld_pipe_q[0] ? s1_sync_q : s2_sync_q;

      rsp_valid_d = vld_pipe_q[1];
      rsp_addr_d  = vld_pipe_q[1] ? s2_addr_q : rsp_addr_q;
      rsp_pos_d   = vld_pipe_q[1] ? old_pos   : rsp_pos_q;
      rsp_wrap_d  = vld_pipe_q[1] ? new_wrap  : rsp_wrap_q;

      wb_vld_d  = ram_we;
      wb_addr_d = ram_waddr;
      wb_data_d = ram_wdata;
      busy_d    = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLEAR;
         clr_addr_q  <= '0;
         vld_pipe_q  <= '0;
         s1_addr_q   <= '0;
         s1_inc_q    <= '0;
         s1_sync_q   <= 1'b0;
         s2_addr_q   <= '0;
         s2_inc_q    <= '0;
         s2_sync_q   <= 1'b0;
         wb_vld_q    <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_pos_q   <= '0;
         rsp_wrap_q  <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         vld_pipe_q  <= vld_pipe_d;
         s1_addr_q   <= s1_addr_d;
         s1_inc_q    <= s1_inc_d;
         s1_sync_q   <= s1_sync_d;
         s2_addr_q   <= s2_addr_d;
         s2_inc_q    <= s2_inc_d;
         s2_sync_q   <= s2_sync_d;
         wb_vld_q    <= wb_vld_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_pos_q   <= rsp_pos_d;
         rsp_wrap_q  <= rsp_wrap_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      rd_q <= mem[s1_addr_q];
   end
endmodule

// File: tb/tb_sample_pos_accum_ram.sv
// Bench for sample_pos_accum_ram: vector table, random stream against a per-channel
// position model, and hand sequences for clear, drain and reset corners.
module tb_sample_pos_accum_ram;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int NCH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, clear_req, busy, req_valid, req_ready, req_sync;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_inc;
   logic          rsp_valid, rsp_wrap;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_pos;

   sample_pos_accum_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_inc(req_inc), .req_sync(req_sync), .rsp_valid(rsp_valid),
      .rsp_addr(rsp_addr), .rsp_pos(rsp_pos), .rsp_wrap(rsp_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {int unsigned addr; int unsigned pos; int unsigned wrap; int unsigned due;} rsp_t;
   typedef struct {int unsigned addr; int unsigned inc; int unsigned sync; int unsigned pos; int unsigned wrap;} vec_t;

   int unsigned n_cmp, n_bad, nidx;
   bit          armed;
   rsp_t        exp_q[$];
   rsp_t        got_q[$];
   rsp_t        last;
   int unsigned model[NCH];
   vec_t        tbl[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   task automatic zero_model();
      foreach (model[i]) model[i] = 0;
   endtask

   // Runs at every falling edge: check responses, then record what the next
   // rising edge will accept. A response is due three falling edges later.
   task automatic mon_step();
      int unsigned a, s;
      rsp_t e;
      nidx++;
      if (armed) begin
         while (exp_q.size() > 0 && exp_q[0].due < nidx) begin
            flag($sformatf("missing_rsp addr=%0d pos=%0h", exp_q[0].addr, exp_q[0].pos));
            exp_q.delete(0);
         end
         if (rsp_valid === 1'b1) begin
            e.addr = rsp_addr; e.pos = rsp_pos; e.wrap = rsp_wrap; e.due = nidx;
            got_q.push_back(e);
            if (exp_q.size() == 0 || exp_q[0].due != nidx) begin
               flag($sformatf("unexpected_rsp addr=%0d pos=%0h", rsp_addr, rsp_pos));
            end else begin
               e = exp_q[0];
               exp_q.delete(0);
               chk("rsp_addr", rsp_addr, e.addr);
               chk("rsp_pos", rsp_pos, e.pos);
               chk("rsp_wrap", rsp_wrap, e.wrap);
               last = e;
            end
         end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("hold_addr", rsp_addr, last.addr);
            chk("hold_pos", rsp_pos, last.pos);
            chk("hold_wrap", rsp_wrap, last.wrap);
         end
      end
      if (reset) begin
         armed = 1;
         exp_q.delete();
         last = '{0, 0, 0, 0};
         zero_model();
      end else if (armed) begin
         if (clear_req) zero_model();
         if (req_valid && req_ready) begin
            a = req_addr;
            s = model[a] + req_inc;
            e.addr = a;
            e.pos  = model[a];
            e.wrap = req_sync ? 0 : (s >> DW) & 1;
            e.due  = nidx + 3;
            exp_q.push_back(e);
            model[a] = req_sync ? 0 : s % (1 << DW);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int unsigned a, input int unsigned i, input bit s);
      req_valid = 1; req_addr = AW'(a); req_inc = DW'(i); req_sync = s;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            @(posedge clk);
            #1;
            req_valid = 0;
            return;
         end
      end
      flag("send_timeout");
      req_valid = 0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            chk("ready_after_busy", req_ready, 1);
            return;
         end
         chk("ready_while_busy", req_ready, 0);
         cnt++;
      end
      flag("busy_timeout");
   endtask

   initial begin
      int cnt;
      reset = 1; clear_req = 0; req_valid = 0; req_addr = '0; req_inc = '0; req_sync = 0;
      n_cmp = 0; n_bad = 0; nidx = 0; armed = 0;
      last = '{0, 0, 0, 0};
      zero_model();
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
         begin
            #500000;
            flag("global_timeout");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      join_none

      // Reset values, then the power-up sweep.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 1);
      chk("reset_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_addr", rsp_addr, 0);
      chk("reset_rsp_pos", rsp_pos, 0);
      chk("reset_rsp_wrap", rsp_wrap, 0);
      @(posedge clk);
      #1;
      reset = 0;
      wait_idle(cnt);
      chk("busy_cycles_after_reset", cnt, 256);
      step();

      // Reset mid-sweep restarts from address 0.
      reset = 1; step(); reset = 0;
      repeat (100) step();
      reset = 1; step(); reset = 0;
      wait_idle(cnt);
      chk("busy_cycles_midsweep_reset", cnt, 256);
      step();
      for (int c = 0; c < NCH; c++) send(c, 0, 0);

      // Vector table, issued back to back.
      tbl[0]  = '{5, 'h1000, 0, 'h0000, 0};
      tbl[1]  = '{5, 'h1000, 0, 'h1000, 0};
      tbl[2]  = '{5, 'h1000, 0, 'h2000, 0};
      tbl[3]  = '{5, 'h1000, 0, 'h3000, 0};
      tbl[4]  = '{3, 'hF000, 0, 'h0000, 0};
      tbl[5]  = '{7, 'h4000, 0, 'h0000, 0};
      tbl[6]  = '{3, 'h2000, 0, 'hF000, 1};
      tbl[7]  = '{7, 'h1234, 1, 'h4000, 0};
      tbl[8]  = '{3, 'h0001, 0, 'h1000, 0};
      tbl[9]  = '{7, 'h0005, 0, 'h0000, 0};
      tbl[10] = '{5, 'hC000, 0, 'h4000, 1};
      tbl[11] = '{5, 'h0001, 0, 'h0000, 0};
      tbl[12] = '{7, 'h0000, 0, 'h0005, 0};
      tbl[13] = '{7, 'h0000, 1, 'h0005, 0};
      tbl[14] = '{7, 'hFFFF, 0, 'h0000, 0};
      tbl[15] = '{7, 'h0001, 0, 'hFFFF, 1};
      tbl[16] = '{7, 'h0000, 0, 'h0000, 0};
      tbl[17] = '{3, 'hFFFF, 1, 'h1001, 0};
      tbl[18] = '{3, 'h0000, 0, 'h0000, 0};
      repeat (4) step();
      got_q.delete();
      for (int i = 0; i < 19; i++) send(tbl[i].addr, tbl[i].inc, tbl[i].sync[0]);
      repeat (4) step();
      chk("tbl_count", got_q.size(), 19);
      for (int i = 0; i < 19; i++) begin
         if (i < got_q.size()) begin
            chk($sformatf("tbl%0d_addr", i), got_q[i].addr, tbl[i].addr);
            chk($sformatf("tbl%0d_pos", i), got_q[i].pos, tbl[i].pos);
            chk($sformatf("tbl%0d_wrap", i), got_q[i].wrap, tbl[i].wrap);
         end
      end

      // Random stream, biased to a few channels so hazards are frequent.
      for (int r = 0; r < 400; r++) begin
         int unsigned a;
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NCH - 1) : $urandom_range(0, 3);
         send(a, $urandom_range(0, 'hFFFF), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) step();
      end

      // Clear while streaming; further clears during drain and sweep are ignored.
      for (int k = 0; k < 6; k++) begin
         req_valid = 1; req_addr = AW'(k % 2); req_inc = DW'(k * 'h111 + 1); req_sync = 0;
         clear_req = (k == 5);
         @(negedge clk);
         chk((k == 5) ? "ready_on_clear" : "ready_stream", req_ready, (k == 5) ? 0 : 1);
         @(posedge clk);
         #1;
      end
      clear_req = 0;
      fork
         begin
            step(); clear_req = 1; step(); clear_req = 0;
            repeat (60) step();
            clear_req = 1; step(); clear_req = 0;
         end
      join_none
      wait_idle(cnt);
      n_cmp++;
      if (!(cnt >= 257 && cnt <= 258)) begin
         n_bad++;
         $display("FAIL busy_drain_clear: got %0d cycles, want 257..258", cnt);
      end
      step();
      req_valid = 0;
      for (int c = 0; c < NCH; c++) send(c, 0, 0);

      // Reset during a back-to-back stream drops the in-flight requests.
      for (int k = 0; k < 6; k++) begin
         req_valid = 1; req_addr = AW'(k % 2); req_inc = DW'('h100 * (k + 1)); req_sync = 0;
         reset = (k == 5);
         step();
      end
      reset = 0; req_valid = 0;
      wait_idle(cnt);
      chk("busy_cycles_stream_reset", cnt, 256);
      step();
      for (int r = 0; r < 40; r++) send(r % 2, $urandom_range(0, 'hFFFF), 0);
      send(0, 0, 0);
      send(1, 0, 0);
      repeat (6) step();
      chk("pending_at_end", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sample_pos_accum_ram.md
SAMPLE_POS_ACCUM_RAM -- requirements
Module: sample_pos_accum_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: number of channels (harmonics) is 2^ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 16: width of each stored sample position.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear_req  input  1  pulse; requests zeroing of all stored positions.
REQ-007 busy  output  1  high while draining or clearing.
REQ-008 req_valid  input  1  an accumulate request is presented.
REQ-009 req_ready  output  1  the block accepts a request this cycle.
REQ-010 req_addr  input  ADDR_WIDTH  channel index.
REQ-011 req_inc  input  DATA_WIDTH  position increment, unsigned.
REQ-012 req_sync  input  1  hard sync; the channel's position restarts at zero.
REQ-013 rsp_valid  output  1  one-cycle strobe; response fields are valid.
REQ-014 rsp_addr  output  ADDR_WIDTH  channel of the response.
REQ-015 rsp_pos  output  DATA_WIDTH  channel position before this request's update.
REQ-016 rsp_wrap  output  1  the update overflowed DATA_WIDTH.

Function
REQ-017 Storage SHALL be a 2^ADDR_WIDTH x DATA_WIDTH RAM with a registered read, inferable as block RAM; no initial-value dependence.
REQ-018 FSM states SHALL be CLEAR, RUN and DRAIN.
REQ-019 CLEAR: write 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle, in ascending order; then go to RUN; duration is exactly 2^ADDR_WIDTH cycles.
REQ-020 req_ready SHALL be 1 only in RUN with clear_req low; busy SHALL be 1 in CLEAR and DRAIN.
REQ-021 A request is accepted on the edge where req_valid and req_ready are both 1; back-to-back acceptance every cycle SHALL be supported.
REQ-022 Accept at edge T -> RAM read at T+1 -> rsp_valid high for the cycle after edge T+2, with writeback at edge T+2; latency is fixed at 2 cycles.
REQ-023 Writeback: new = (pos + req_inc) mod 2^DATA_WIDTH; rsp_wrap = carry out of that addition.
REQ-024 req_sync=1: writeback value 0, rsp_pos = old position, rsp_wrap = 0.
REQ-025 Read-after-write hazards on the same address, accepted 1 or 2 cycles apart, SHALL be forwarded.
REQ-026 Responses SHALL always reflect all earlier accepted requests in acceptance order.
REQ-027 Responses have no backpressure; the consumer SHALL sample every rsp_valid.
REQ-028 rsp_* SHALL hold their last value when rsp_valid is 0.
REQ-029 clear_req in RUN: req_ready drops in the same cycle; enter DRAIN until the pipeline is empty (at most 2 cycles), then CLEAR; in-flight responses complete normally.
REQ-030 clear_req in CLEAR or DRAIN SHALL be ignored; the sweep does not restart.
REQ-031 clear_req together with req_valid in the same cycle: the clear wins and the request is not accepted.

Reset
REQ-032 reset SHALL set state to CLEAR at address 0 and invalidate all pipeline stages.
REQ-033 In-flight requests at reset SHALL produce no response and no writeback.
REQ-034 Reset values: rsp_valid=0, rsp_addr=0, rsp_pos=0, rsp_wrap=0, req_ready=0, busy=1.
REQ-035 Reset asserted mid-sweep SHALL restart the sweep from address 0.

Verification
REQ-036 Release reset (ADDR_WIDTH=8) -> busy high for exactly 256 cycles, req_ready rises after; reading any channel gives rsp_pos=0.
REQ-037 Ch 5, inc 0x1000, four requests back-to-back -> rsp_pos 0x0000, 0x1000, 0x2000, 0x3000, each 2 cycles after accept (forwarding check).
REQ-038 Ch 3 at 0xF000, inc 0x2000 -> rsp_pos=0xF000, rsp_wrap=1; next request returns 0x1000.
REQ-039 Ch 7 at 0x4000 with req_sync=1 -> rsp_pos=0x4000, rsp_wrap=0; next request returns 0.
REQ-040 clear_req while requests are streaming -> accepted responses all emitted, busy for drain + 256 cycles, all channels read 0.
REQ-041 reset pulsed during a back-to-back stream -> no rsp_valid afterwards for in-flight requests, full clear sweep runs, interleaved channels 0/1 accumulate independently.
